// File: rtl/axi_confreg.sv
// AXI4 slave exposing the SoC MMIO registers: LED, synchronised switches, free-running timer, scratch.
// One outstanding read and one outstanding write; the read and write paths run independently.
module axi_confreg #(
    parameter int          ID_WIDTH = 4,
    parameter int          OFF_BITS = 12,
    parameter logic [15:0] LED_RST  = 16'h0000
) (
    input  logic                clock,
    input  logic                reset,
    // read address / data
    input  logic [31:0]         araddr,
    input  logic                arvalid,
    output logic                arready,
    input  logic [ID_WIDTH-1:0] arid,
    input  logic [7:0]          arlen,
    input  logic [2:0]          arsize,
    input  logic [1:0]          arburst,
    output logic [31:0]         rdata,
    output logic [1:0]          rresp,
    output logic [ID_WIDTH-1:0] rid,
    output logic                rlast,
    output logic                rvalid,
    input  logic                rready,
    // write address / data / response
    input  logic [31:0]         awaddr,
    input  logic                awvalid,
    output logic                awready,
    input  logic [ID_WIDTH-1:0] awid,
    input  logic [7:0]          awlen,
    input  logic [2:0]          awsize,
    input  logic [1:0]          awburst,
    input  logic [31:0]         wdata,
    input  logic [3:0]          wstrb,
    input  logic                wlast,
    input  logic                wvalid,
    output logic                wready,
    output logic [1:0]          bresp,
    output logic [ID_WIDTH-1:0] bid,
    output logic                bvalid,
    input  logic                bready,
    // board I/O
    output logic [15:0]         led,
    input  logic [15:0]         sw
);

    localparam logic [OFF_BITS-1:0] OFF_LED     = OFF_BITS'(32'h000);
    localparam logic [OFF_BITS-1:0] OFF_SW      = OFF_BITS'(32'h004);
    localparam logic [OFF_BITS-1:0] OFF_TIMER   = OFF_BITS'(32'h008);
    localparam logic [OFF_BITS-1:0] OFF_SCRATCH = OFF_BITS'(32'h00C);
    localparam logic [OFF_BITS-1:0] ADDR_STEP   = OFF_BITS'(32'h004);

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic       R_IDLE = 1'b0;
    localparam logic       R_DATA = 1'b1;
    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;

    // register file
    logic [15:0] led_reg;
    logic [31:0] timer_reg;
    logic [31:0] scratch_reg;
    logic [15:0] sw_meta_reg;
    logic [15:0] sw_sync_reg;

    // read channel state
    logic                r_state_reg;
    logic                arready_reg;
    logic                rvalid_reg;
    logic                rlast_reg;
    logic [31:0]         rdata_reg;
    logic [1:0]          rresp_reg;
    logic [ID_WIDTH-1:0] rid_reg;
    logic [OFF_BITS-1:0] r_addr_reg;
    logic [7:0]          r_len_reg;
    logic [7:0]          r_cnt_reg;
    logic [1:0]          r_burst_reg;

    // write channel state
    logic [1:0]          w_state_reg;
    logic                awready_reg;
    logic                wready_reg;
    logic                bvalid_reg;
    logic [1:0]          bresp_reg;
    logic [ID_WIDTH-1:0] bid_reg;
    logic [OFF_BITS-1:0] w_addr_reg;
    logic [7:0]          w_len_reg;
    logic [7:0]          w_cnt_reg;
    logic [1:0]          w_burst_reg;
    logic                w_err_reg;

    // combinational helpers
    logic [OFF_BITS-1:0] r_addr_next;
    logic [7:0]          r_cnt_next;
    logic [OFF_BITS-1:0] rd_off;
    logic [31:0]         rd_data;
    logic                rd_err;
    logic [OFF_BITS-1:0] w_addr_next;
    logic                w_en;
    logic                wr_err;
    logic [31:0]         timer_merged;
    logic [31:0]         scratch_merged;
    logic [15:0]         led_merged;
    logic                unused_inputs;

    // Only the window offset matters; size is fixed at 4 B and the beat count overrides wlast.
    assign unused_inputs = ^{araddr[31:OFF_BITS], awaddr[31:OFF_BITS], arsize, awsize, wlast};

    assign arready = arready_reg;
    assign rvalid  = rvalid_reg;
    assign rlast   = rlast_reg;
    assign rdata   = rdata_reg;
    assign rresp   = rresp_reg;
    assign rid     = rid_reg;
    assign awready = awready_reg;
    assign wready  = wready_reg;
    assign bvalid  = bvalid_reg;
    assign bresp   = bresp_reg;
    assign bid     = bid_reg;
    assign led     = led_reg;

    assign r_addr_next = (r_burst_reg == BURST_FIXED) ? r_addr_reg : r_addr_reg + ADDR_STEP;
    assign r_cnt_next  = r_cnt_reg + 8'd1;
    assign w_addr_next = (w_burst_reg == BURST_FIXED) ? w_addr_reg : w_addr_reg + ADDR_STEP;

    // The same mux serves the first beat (straight from araddr) and every following beat.
    assign rd_off = (r_state_reg == R_IDLE) ? araddr[OFF_BITS-1:0] : r_addr_next;

    always_comb begin
        rd_data = 32'h0;
        rd_err  = 1'b0;
        case (rd_off)
            OFF_LED:     rd_data = {16'h0, led_reg};
            OFF_SW:      rd_data = {16'h0, sw_sync_reg};
            OFF_TIMER:   rd_data = timer_reg;
            OFF_SCRATCH: rd_data = scratch_reg;
            default:     rd_err  = 1'b1;
        endcase
    end

    always_comb begin
        wr_err = 1'b1;
        case (w_addr_reg)
            OFF_LED, OFF_SW, OFF_TIMER, OFF_SCRATCH: wr_err = 1'b0;
            default:                                 wr_err = 1'b1;
        endcase
    end

    assign w_en = (w_state_reg == W_DATA) && wready_reg && wvalid;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_word_lane
            assign timer_merged[8*gi +: 8]   = wstrb[gi] ? wdata[8*gi +: 8] : timer_reg[8*gi +: 8];
            assign scratch_merged[8*gi +: 8] = wstrb[gi] ? wdata[8*gi +: 8] : scratch_reg[8*gi +: 8];
        end
        for (gi = 0; gi < 2; gi++) begin : g_led_lane
            assign led_merged[8*gi +: 8] = wstrb[gi] ? wdata[8*gi +: 8] : led_reg[8*gi +: 8];
        end
    endgenerate

    // Register file; a timer write replaces that cycle's increment.
    always_ff @(posedge clock) begin
        if (reset) begin
            led_reg     <= LED_RST;
            timer_reg   <= 32'h0;
            scratch_reg <= 32'h0;
            sw_meta_reg <= 16'h0;
            sw_sync_reg <= 16'h0;
        end else begin
            sw_meta_reg <= sw;
            sw_sync_reg <= sw_meta_reg;
            if (w_en && (w_addr_reg == OFF_TIMER)) begin
                timer_reg <= timer_merged;
            end else begin
                timer_reg <= timer_reg + 32'd1;
            end
            if (w_en && (w_addr_reg == OFF_LED)) begin
                led_reg <= led_merged;
            end
            if (w_en && (w_addr_reg == OFF_SCRATCH)) begin
                scratch_reg <= scratch_merged;
            end
        end
    end

    // Read FSM: beat data is captured at the handshake edge and held until accepted.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state_reg <= R_IDLE;
            arready_reg <= 1'b0;
            rvalid_reg  <= 1'b0;
            rlast_reg   <= 1'b0;
            rdata_reg   <= 32'h0;
            rresp_reg   <= RESP_OKAY;
            rid_reg     <= '0;
            r_addr_reg  <= '0;
            r_len_reg   <= 8'h0;
            r_cnt_reg   <= 8'h0;
            r_burst_reg <= 2'b00;
        end else begin
            case (r_state_reg)
                R_IDLE: begin
                    arready_reg <= 1'b1;
                    if (arvalid && arready_reg) begin
                        arready_reg <= 1'b0;
                        rid_reg     <= arid;
                        r_addr_reg  <= araddr[OFF_BITS-1:0];
                        r_len_reg   <= arlen;
                        r_burst_reg <= arburst;
                        r_cnt_reg   <= 8'h0;
                        rdata_reg   <= rd_data;
                        rresp_reg   <= rd_err ? RESP_SLVERR : RESP_OKAY;
                        rlast_reg   <= (arlen == 8'h0);
                        rvalid_reg  <= 1'b1;
                        r_state_reg <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (rready) begin
                        if (rlast_reg) begin
                            rvalid_reg  <= 1'b0;
                            rlast_reg   <= 1'b0;
                            arready_reg <= 1'b1;
                            r_state_reg <= R_IDLE;
                        end else begin
                            r_addr_reg <= r_addr_next;
                            r_cnt_reg  <= r_cnt_next;
                            rdata_reg  <= rd_data;
                            rresp_reg  <= rd_err ? RESP_SLVERR : RESP_OKAY;
                            rlast_reg  <= (r_cnt_next == r_len_reg);
                        end
                    end
                end
                default: r_state_reg <= R_IDLE;
            endcase
        end
    end

    // Write FSM: the beat count alone decides the last beat; errors accumulate over the burst.
    always_ff @(posedge clock) begin
        if (reset) begin
            w_state_reg <= W_IDLE;
            awready_reg <= 1'b0;
            wready_reg  <= 1'b0;
            bvalid_reg  <= 1'b0;
            bresp_reg   <= RESP_OKAY;
            bid_reg     <= '0;
            w_addr_reg  <= '0;
            w_len_reg   <= 8'h0;
            w_cnt_reg   <= 8'h0;
            w_burst_reg <= 2'b00;
            w_err_reg   <= 1'b0;
        end else begin
            case (w_state_reg)
                W_IDLE: begin
                    awready_reg <= 1'b1;
                    if (awvalid && awready_reg) begin
                        awready_reg <= 1'b0;
                        wready_reg  <= 1'b1;
                        bid_reg     <= awid;
                        w_addr_reg  <= awaddr[OFF_BITS-1:0];
                        w_len_reg   <= awlen;
                        w_burst_reg <= awburst;
                        w_cnt_reg   <= 8'h0;
                        w_err_reg   <= 1'b0;
                        w_state_reg <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_en) begin
                        w_addr_reg <= w_addr_next;
                        w_cnt_reg  <= w_cnt_reg + 8'd1;
                        w_err_reg  <= w_err_reg | wr_err;
                        if (w_cnt_reg == w_len_reg) begin
                            wready_reg  <= 1'b0;
                            bvalid_reg  <= 1'b1;
                            bresp_reg   <= (w_err_reg | wr_err) ? RESP_SLVERR : RESP_OKAY;
                            w_state_reg <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        bvalid_reg  <= 1'b0;
                        awready_reg <= 1'b1;
                        w_state_reg <= W_IDLE;
                    end
                end
                default: w_state_reg <= W_IDLE;
            endcase
        end
    end

endmodule
